hazard_stall_controller: RTL and testbench
==========================================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max MEM_WAIT cycles before forced release (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 memRead_IdEx  input  1  instruction in ID/EX is a load.
REQ-005 rtAddress_IdEx  input  5  load destination register in ID/EX.
REQ-006 rsAddress_IfId, rtAddress_IfId  input  5 each  source registers of instruction in IF/ID.
REQ-007 usesRt_IfId  input  1  IF/ID instruction reads rt.
REQ-008 branchTaken_Ex  input  1  branch/jump in EX resolved taken.
REQ-009 memReq_ExMem  input  1  EX/MEM instruction accesses data memory.
REQ-010 memReady  input  1  data memory completes access this cycle.
REQ-011 pcWrite, ifIdWrite, idExWrite, exMemWrite  output  1 each  stage register enables.
REQ-012 ifIdFlush, idExFlush  output  1 each  replace stage contents with NOP.
REQ-013 memTimeout  output  1  sticky timeout flag.
REQ-014 stallCycles  output  16  stall statistics counter.

Function
REQ-015 FSM states: RUN, MEM_WAIT; control outputs are combinational decodes of state and inputs.
REQ-016 Defaults (no hazard): all enables 1, both flushes 0.
REQ-017 Memory stall: in RUN, memReq_ExMem=1 and memReady=0 -> pcWrite, ifIdWrite, idExWrite, exMemWrite all 0, flushes 0, next state MEM_WAIT.
REQ-018 In MEM_WAIT: while memReady=0 and waitCnt<MEM_TIMEOUT, all enables 0, waitCnt increments each cycle.
REQ-019 In MEM_WAIT: memReady=1 -> enables 1 that cycle (pipeline advances), waitCnt cleared, next state RUN.
REQ-020 In MEM_WAIT: waitCnt==MEM_TIMEOUT with memReady=0 -> memTimeout set to 1, enables 1 that cycle, waitCnt cleared, next state RUN.
REQ-021 Load-use hazard = memRead_IdEx & rtAddress_IdEx!=0 & (rtAddress_IdEx==rsAddress_IfId | (usesRt_IfId & rtAddress_IdEx==rtAddress_IfId)).
REQ-022 Load-use in RUN (no memory stall, no branch) -> pcWrite=0, ifIdWrite=0, idExFlush=1, idExWrite=1, exMemWrite=1; exactly one bubble, no state change.
REQ-023 branchTaken_Ex in RUN (no memory stall) -> ifIdFlush=1, idExFlush=1, all enables 1.
REQ-024 Priority: memory stall > branch flush > load-use; branch with load-use -> branch response only.
REQ-025 Branch during memory stall: no flush while frozen; branch held in EX, flush issued on first RUN cycle the condition is re-evaluated.
REQ-026 memTimeout cleared only by reset.
REQ-027 waitCnt width 8 bits; never exceeds MEM_TIMEOUT.

Reset
REQ-028 reset_n=0 asynchronously forces state RUN, waitCnt 0, memTimeout 0, stallCycles 0.
REQ-029 During reset outputs: enables 1, flushes 0; reset asserted in MEM_WAIT abandons the wait with no timeout flag.
REQ-030 First edge after reset_n rises evaluates from RUN.

Configuration
REQ-031 Macro HAZARD_STALL_STATS_EN defined -> stallCycles increments every cycle pcWrite=0 outside reset, saturating at 16'hFFFF.
REQ-032 Macro undefined -> stallCycles port present, constant 0, no counter logic.

Verification
REQ-033 Load rt=5 in ID/EX, IF/ID rs=5 -> one cycle pcWrite=0, ifIdWrite=0, idExFlush=1; next cycle all defaults.
REQ-034 Load rt=0 with IF/ID rs=0 -> no stall; load rt=7, IF/ID rt=7, usesRt_IfId=0 -> no stall.
REQ-035 memReq_ExMem=1, memReady low 3 cycles then high -> enables 0 for 3 cycles, 1 on 4th, state RUN, memTimeout 0.
REQ-036 MEM_TIMEOUT=4, memReady held 0 -> release after 4 MEM_WAIT cycles, memTimeout=1 and remains 1 until reset_n=0.
REQ-037 branchTaken_Ex and load-use same cycle -> ifIdFlush=1, idExFlush=1, pcWrite=1; with memory stall also active -> all enables 0, no flush.
REQ-038 With HAZARD_STALL_STATS_EN, after REQ-035 sequence stallCycles=3; reset_n pulsed mid-MEM_WAIT -> stallCycles 0, state RUN immediately.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: memory-wait freeze, taken-branch flush, load-use bubble.
// Optional stall statistics counter enabled by defining HAZARD_STALL_STATS_EN.
module hazard_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memRead_IdEx,
  input  logic [4:0]  rtAddress_IdEx,
  input  logic [4:0]  rsAddress_IfId,
  input  logic [4:0]  rtAddress_IfId,
  input  logic        usesRt_IfId,
  input  logic        branchTaken_Ex,
  input  logic        memReq_ExMem,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        idExWrite,
  output logic        exMemWrite,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        memTimeout,
  output logic [15:0] stallCycles
);

  // state    | meaning
  // RUN      | pipeline flowing; hazards decoded from current inputs
  // MEM_WAIT | pipeline frozen until memReady or the wait budget runs out
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       mem_stall;
  logic       load_use;

  assign mem_stall = memReq_ExMem & ~memReady;
  assign load_use  = memRead_IdEx & (rtAddress_IdEx != 5'd0) &
                     ((rtAddress_IdEx == rsAddress_IfId) |
                      (usesRt_IfId & (rtAddress_IdEx == rtAddress_IfId)));

  always_comb begin
    pcWrite       = 1'b1;
    ifIdWrite     = 1'b1;
    idExWrite     = 1'b1;
    exMemWrite    = 1'b1;
    ifIdFlush     = 1'b0;
    idExFlush     = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    // Outputs held at pass-through values while reset is asserted.
    if (reset_n) begin
      if (state_q == MEM_WAIT) begin
        if (memReady) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q >= TIMEOUT) begin
          mem_timeout_d = 1'b1;
          state_d       = RUN;
          wait_cnt_d    = 8'd0;
        end else begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          idExWrite  = 1'b0;
          exMemWrite = 1'b0;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end else begin
        if (mem_stall) begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          idExWrite  = 1'b0;
          exMemWrite = 1'b0;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd0;
        end else if (branchTaken_Ex) begin
          ifIdFlush = 1'b1;
          idExFlush = 1'b1;
        end else if (load_use) begin
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          idExFlush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign memTimeout = mem_timeout_q;

`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pcWrite && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCycles = stall_cnt_q;
`else
  assign stallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: constant vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a cycle-level reference model.
module tb_hazard_stall_controller;

  localparam int TO = 4;

  typedef struct {
    logic       mr;
    logic [4:0] rt_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       uses_rt;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic [5:0] exp;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        memRead_IdEx;
  logic [4:0]  rtAddress_IdEx;
  logic [4:0]  rsAddress_IfId;
  logic [4:0]  rtAddress_IfId;
  logic        usesRt_IfId;
  logic        branchTaken_Ex;
  logic        memReq_ExMem;
  logic        memReady;
  logic        pcWrite, ifIdWrite, idExWrite, exMemWrite;
  logic        ifIdFlush, idExFlush;
  logic        memTimeout;
  logic [15:0] stallCycles;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: waiting flag, cycles spent waiting, sticky flag, stall count.
  bit m_wait   = 0;
  int m_waited = 0;
  bit m_to     = 0;
  int m_stalls = 0;

  hazard_stall_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .memRead_IdEx  (memRead_IdEx),
    .rtAddress_IdEx(rtAddress_IdEx),
    .rsAddress_IfId(rsAddress_IfId),
    .rtAddress_IfId(rtAddress_IfId),
    .usesRt_IfId   (usesRt_IfId),
    .branchTaken_Ex(branchTaken_Ex),
    .memReq_ExMem  (memReq_ExMem),
    .memReady      (memReady),
    .pcWrite       (pcWrite),
    .ifIdWrite     (ifIdWrite),
    .idExWrite     (idExWrite),
    .exMemWrite    (exMemWrite),
    .ifIdFlush     (ifIdFlush),
    .idExFlush     (idExFlush),
    .memTimeout    (memTimeout),
    .stallCycles   (stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [5:0] ctl();
    return {pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush};
  endfunction

  function automatic logic [15:0] exp_stats();
`ifdef HAZARD_STALL_STATS_EN
    return 16'(m_stalls);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic vec_t mk(input logic mr, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                              input logic [4:0] rt_id, input logic uses_rt, input logic br,
                              input logic mreq, input logic mrdy, input logic [5:0] exp);
    vec_t v;
    v.mr = mr; v.rt_ex = rt_ex; v.rs_id = rs_id; v.rt_id = rt_id; v.uses_rt = uses_rt;
    v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
    return v;
  endfunction

  // Expected {pcWrite,ifIdWrite,idExWrite,exMemWrite,ifIdFlush,idExFlush} from the rules.
  function automatic logic [5:0] model_ctl(input vec_t v);
    bit hz;
    hz = v.mr && (v.rt_ex != 0) && ((v.rt_ex == v.rs_id) || (v.uses_rt && (v.rt_ex == v.rt_id)));
    if (m_wait) return (v.mrdy || (m_waited == TO)) ? 6'b111100 : 6'b000000;
    if (v.mreq && !v.mrdy) return 6'b000000;
    if (v.br) return 6'b111111;
    if (hz) return 6'b001101;
    return 6'b111100;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks at negedge, steps the model at posedge.
  task automatic apply(input vec_t v, input bit use_tbl, input string name);
    logic [5:0] m;
    memRead_IdEx   = v.mr;
    rtAddress_IdEx = v.rt_ex;
    rsAddress_IfId = v.rs_id;
    rtAddress_IfId = v.rt_id;
    usesRt_IfId    = v.uses_rt;
    branchTaken_Ex = v.br;
    memReq_ExMem   = v.mreq;
    memReady       = v.mrdy;
    m = model_ctl(v);
    @(negedge clk);
    check({name, "_ctl"}, {10'd0, ctl()}, {10'd0, (use_tbl ? v.exp : m)});
    check({name, "_timeout"}, {15'd0, memTimeout}, {15'd0, m_to});
    check({name, "_stats"}, stallCycles, exp_stats());
    @(posedge clk);
    if (!m[5] && m_stalls < 65535) m_stalls++;
    if (m_wait) begin
      if (v.mrdy) begin
        m_wait = 0; m_waited = 0;
      end else if (m_waited == TO) begin
        m_to = 1; m_wait = 0; m_waited = 0;
      end else begin
        m_waited++;
      end
    end else if (v.mreq && !v.mrdy) begin
      m_wait = 1; m_waited = 0;
    end
    #1;
  endtask

  // Asynchronous reset with hazardous inputs present; outputs must be pass-through at once.
  task automatic do_reset(input string name);
    memRead_IdEx = 1; rtAddress_IdEx = 5'd5; rsAddress_IfId = 5'd5; rtAddress_IfId = 5'd0;
    usesRt_IfId = 0; branchTaken_Ex = 1; memReq_ExMem = 1; memReady = 0;
    reset_n = 1'b0;
    #1;
    check({name, "_rst_ctl"}, {10'd0, ctl()}, 16'h003C);
    check({name, "_rst_timeout"}, {15'd0, memTimeout}, 16'h0000);
    check({name, "_rst_stats"}, stallCycles, 16'h0000);
    m_wait = 0; m_waited = 0; m_to = 0; m_stalls = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  vec_t tbl[12];
  vec_t z;

  initial begin
    reset_n = 1'b1;
    memRead_IdEx = 0; rtAddress_IdEx = 0; rsAddress_IfId = 0; rtAddress_IfId = 0;
    usesRt_IfId = 0; branchTaken_Ex = 0; memReq_ExMem = 0; memReady = 0;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b111100);

    tbl[0]  = mk(0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 6'b111100);
    tbl[1]  = mk(1, 5'd5,  5'd5,  5'd0,  0, 0, 0, 0, 6'b001101);
    tbl[2]  = mk(0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 6'b111100);
    tbl[3]  = mk(1, 5'd0,  5'd0,  5'd0,  1, 0, 0, 0, 6'b111100);
    tbl[4]  = mk(1, 5'd7,  5'd1,  5'd7,  0, 0, 0, 0, 6'b111100);
    tbl[5]  = mk(1, 5'd7,  5'd1,  5'd7,  1, 0, 0, 0, 6'b001101);
    tbl[6]  = mk(0, 5'd5,  5'd5,  5'd5,  1, 0, 0, 0, 6'b111100);
    tbl[7]  = mk(0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 1, 6'b111111);
    tbl[8]  = mk(1, 5'd9,  5'd9,  5'd0,  0, 1, 0, 0, 6'b111111);
    tbl[9]  = mk(1, 5'd9,  5'd9,  5'd0,  0, 0, 1, 1, 6'b001101);
    tbl[10] = mk(1, 5'd31, 5'd31, 5'd0,  0, 0, 0, 1, 6'b001101);
    tbl[11] = mk(1, 5'd3,  5'd4,  5'd2,  1, 0, 1, 1, 6'b111100);

    @(posedge clk);
    #1;
    do_reset("init");
    for (int i = 0; i < 12; i++) apply(tbl[i], 1, $sformatf("tbl%0d", i));

    // Memory wait of three frozen cycles, then ready.
    do_reset("mw");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b000000), 1, "mw_enter");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b000000), 1, "mw_wait1");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b000000), 1, "mw_wait2");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 6'b111100), 1, "mw_ready");
`ifdef HAZARD_STALL_STATS_EN
    check("mw_stats3", stallCycles, 16'd3);
`else
    check("mw_stats0", stallCycles, 16'd0);
`endif
    apply(z, 1, "mw_run");
    check("mw_no_timeout", {15'd0, memTimeout}, 16'h0000);

    // Branch and load-use together, alone and under a memory stall.
    apply(mk(1, 5'd6, 5'd6, 5'd0, 0, 1, 0, 0, 6'b111111), 1, "br_lu");
    apply(mk(1, 5'd6, 5'd6, 5'd0, 0, 1, 1, 0, 6'b000000), 1, "br_lu_mem");
    apply(mk(1, 5'd6, 5'd6, 5'd0, 0, 1, 1, 1, 6'b111100), 1, "br_frozen_rel");
    apply(mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 6'b111111), 1, "br_after_run");

    // Timeout after TO frozen wait cycles; flag is sticky until reset.
    do_reset("to");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b000000), 1, "to_enter");
    for (int i = 0; i < TO; i++) apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b000000), 1, "to_wait");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b111100), 1, "to_release");
    check("to_flag_set", {15'd0, memTimeout}, 16'h0001);
    apply(z, 1, "to_after");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b000000), 1, "to_stall2");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 6'b111100), 1, "to_ready2");
    apply(z, 1, "to_after2");
    check("to_flag_sticky", {15'd0, memTimeout}, 16'h0001);

    // Reset pulsed in the middle of a memory wait.
    do_reset("mid");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b000000), 1, "mid_enter");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 6'b000000), 1, "mid_wait");
    do_reset("mid_pulse");
    apply(z, 1, "mid_run");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      vec_t v;
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd");
      end
      v.mr      = 1'($urandom_range(0, 1));
      v.rt_ex   = 5'($urandom_range(0, 3));
      v.rs_id   = 5'($urandom_range(0, 3));
      v.rt_id   = 5'($urandom_range(0, 3));
      v.uses_rt = 1'($urandom_range(0, 1));
      v.br      = ($urandom_range(0, 3) == 0);
      v.mreq    = 1'($urandom_range(0, 1));
      v.mrdy    = ($urandom_range(0, 2) == 0);
      v.exp     = 6'b0;
      apply(v, 0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
